// File: rtl/imem_loader_if.sv
// Byte-stream handshake and imem write-port bundle between a byte source,
// the boot loader and port 1 of the instruction memory.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 24
);
  logic [7:0]        iw_byte;
  logic              iw_byte_valid;
  logic              ow_byte_ready;
  logic              ow_mem_we;
  logic [ADDR_W-1:0] ow_mem_addr;
  logic [DATA_W-1:0] ow_mem_wdata;

  modport master (
    output iw_byte, iw_byte_valid,
    input  ow_byte_ready, ow_mem_we, ow_mem_addr, ow_mem_wdata
  );

  modport slave (
    input  iw_byte, iw_byte_valid,
    output ow_byte_ready, ow_mem_we, ow_mem_addr, ow_mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: decodes SYNC/addr/len/words/checksum frames into imem writes
// and holds the core in reset until a frame with a good checksum completes.
module imem_loader #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 24,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic          iw_clk,
  input  logic          iw_rst_n,
  imem_loader_if.slave  bus,
  output logic          ow_core_rst,
  output logic          ow_busy,
  output logic          ow_done,
  output logic          ow_err
);

  localparam int unsigned AB     = ADDR_W / 8;
  localparam int unsigned B      = DATA_W / 8;
  localparam int unsigned BCNT_W = 8;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                core_rst_q, core_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                accept_c;
  logic [LEN_W-1:0]    len_c;
  logic [DATA_W-1:0]   word_c;

  assign accept_c = bus.iw_byte_valid && ready_q;
  assign len_c    = {cnt_q[7:0], bus.iw_byte};
  assign word_c   = (word_q << 8) | DATA_W'(bus.iw_byte);

  // State and registered outputs
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Frame decoder; outputs are computed from the next state so they register cleanly
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    maddr_d    = maddr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c && (bus.iw_byte == SYNC)) begin
          state_d    = S_ADDR;
          core_rst_d = 1'b1;
          err_d      = 1'b0;
          csum_d     = '0;
          bcnt_d     = '0;
        end
      end
      S_ADDR: begin
        if (accept_c) begin
          addr_d = (addr_q << 8) | ADDR_W'(bus.iw_byte);
          csum_d = csum_q + bus.iw_byte;
          if (bcnt_q == BCNT_W'(AB - 1)) begin
            bcnt_d  = '0;
            state_d = S_LEN;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      S_LEN: begin
        if (accept_c) begin
          cnt_d  = len_c;
          csum_d = csum_q + bus.iw_byte;
          if (bcnt_q == BCNT_W'(1)) begin
            bcnt_d  = '0;
            state_d = (len_c == '0) ? S_CSUM : S_DATA;
          end else begin
            bcnt_d = BCNT_W'(1);
          end
        end
      end
      S_DATA: begin
        if (accept_c) begin
          word_d = word_c;
          csum_d = csum_q + bus.iw_byte;
          if (bcnt_q == BCNT_W'(B - 1)) begin
            bcnt_d  = '0;
            state_d = S_WRITE;
            we_d    = 1'b1;
            maddr_d = addr_q;
            wdata_d = word_c;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept_c) begin
          state_d = S_IDLE;
          if (bus.iw_byte == csum_q) begin
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_d = (state_d != S_WRITE);
  assign busy_d  = (state_d != S_IDLE);

  assign bus.ow_byte_ready = ready_q;
  assign bus.ow_mem_we     = we_q;
  assign bus.ow_mem_addr   = maddr_q;
  assign bus.ow_mem_wdata  = wdata_q;
  assign ow_core_rst       = core_rst_q;
  assign ow_busy           = busy_q;
  assign ow_done           = done_q;
  assign ow_err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, checksum, wrap, stalls and async reset.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic core_rst, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  frame[$];
  logic [23:0] wa[$];
  logic [23:0] wd[$];
  int          done_cnt = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(24), .DATA_W(24)) bus ();

  imem_loader #(.ADDR_W(24), .DATA_W(24), .SYNC(8'hA5)) dut (
    .iw_clk      (clk),
    .iw_rst_n    (rst_n),
    .bus         (bus),
    .ow_core_rst (core_rst),
    .ow_busy     (busy),
    .ow_done     (done),
    .ow_err      (err)
  );

  // Write/done log sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n && bus.ow_mem_we) begin
      wa.push_back(bus.ow_mem_addr);
      wd.push_back(bus.ow_mem_wdata);
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.iw_byte       = b;
    bus.iw_byte_valid = 1'b1;
    while (!bus.ow_byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'(guard), 32'(0));
    @(posedge clk);
    #1 bus.iw_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int start, input bit stall);
    for (int i = start; i < frame.size(); i++) begin
      if (stall) repeat ($urandom_range(0, 5)) @(negedge clk);
      send(frame[i]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [23:0] a, input logic [23:0] d);
    logic [23:0] oa, od;
    oa = (idx < wa.size()) ? wa[idx] : 'x;
    od = (idx < wd.size()) ? wd[idx] : 'x;
    chk({tag, "_addr"}, 32'(oa), 32'(a));
    chk({tag, "_data"}, 32'(od), 32'(d));
  endtask

  initial begin
    int w0, d0;
    bus.iw_byte       = 8'h00;
    bus.iw_byte_valid = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #7;
    chk("rst_ready", 32'(bus.ow_byte_ready), 32'(1));
    chk("rst_we", 32'(bus.ow_mem_we), 32'(0));
    chk("rst_addr", 32'(bus.ow_mem_addr), 32'(0));
    chk("rst_wdata", 32'(bus.ow_mem_wdata), 32'(0));
    chk("rst_core_rst", 32'(core_rst), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    #4 rst_n = 1'b1;

    // Good frame, back-to-back, with cycle-level timing checks
    w0 = wa.size(); d0 = done_cnt;
    send(8'hA5);
    chk("g_busy_sync", 32'(busy), 32'(1));
    chk("g_core_rst_sync", 32'(core_rst), 32'(1));
    send(8'h00); send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33);
    chk("g_w0_we", 32'(bus.ow_mem_we), 32'(1));
    chk("g_w0_addr", 32'(bus.ow_mem_addr), 32'h10);
    chk("g_w0_data", 32'(bus.ow_mem_wdata), 32'h112233);
    chk("g_w0_ready_dip", 32'(bus.ow_byte_ready), 32'(0));
    @(posedge clk); #1;
    chk("g_w0_we_off", 32'(bus.ow_mem_we), 32'(0));
    chk("g_w0_ready_back", 32'(bus.ow_byte_ready), 32'(1));
    chk("g_w0_addr_hold", 32'(bus.ow_mem_addr), 32'h10);
    send(8'h44); send(8'h55); send(8'h66);
    chk("g_w1_we", 32'(bus.ow_mem_we), 32'(1));
    chk("g_w1_addr", 32'(bus.ow_mem_addr), 32'h11);
    chk("g_w1_data", 32'(bus.ow_mem_wdata), 32'h445566);
    chk("g_w1_ready_dip", 32'(bus.ow_byte_ready), 32'(0));
    send(8'h77);
    chk("g_done", 32'(done), 32'(1));
    chk("g_core_rst_low", 32'(core_rst), 32'(0));
    chk("g_busy_end", 32'(busy), 32'(0));
    chk("g_err", 32'(err), 32'(0));
    @(posedge clk); #1;
    chk("g_done_pulse", 32'(done), 32'(0));
    repeat (2) @(negedge clk);
    chk("g_nwrites", 32'(wa.size() - w0), 32'(2));
    chk("g_ndone", 32'(done_cnt - d0), 32'(1));

    // Bad checksum: same writes, sticky error, core held in reset
    frame = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h78};
    w0 = wa.size(); d0 = done_cnt;
    send_frame(0, 1'b0);
    chk("b_err", 32'(err), 32'(1));
    chk("b_core_rst", 32'(core_rst), 32'(1));
    chk("b_ndone", 32'(done_cnt - d0), 32'(0));
    chk("b_nwrites", 32'(wa.size() - w0), 32'(2));
    chk_wr("b_w0", w0, 24'h000010, 24'h112233);
    chk_wr("b_w1", w0 + 1, 24'h000011, 24'h445566);

    // Following good frame clears the error on its SYNC
    frame[12] = 8'h77;
    d0 = done_cnt;
    send(8'hA5);
    chk("r_err_clear", 32'(err), 32'(0));
    chk("r_core_rst", 32'(core_rst), 32'(1));
    send_frame(1, 1'b0);
    chk("r_core_rel", 32'(core_rst), 32'(0));
    chk("r_ndone", 32'(done_cnt - d0), 32'(1));

    // Garbage bytes ignored, then zero-length frame
    w0 = wa.size(); d0 = done_cnt;
    send(8'h00); send(8'hFF); send(8'h12);
    chk("z_garbage_busy", 32'(busy), 32'(0));
    chk("z_garbage_core_rst", 32'(core_rst), 32'(0));
    send(8'hA5);
    chk("z_sync_core_rst", 32'(core_rst), 32'(1));
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1, 1'b0);
    chk("z_nwrites", 32'(wa.size() - w0), 32'(0));
    chk("z_ndone", 32'(done_cnt - d0), 32'(1));
    chk("z_core_rel", 32'(core_rst), 32'(0));

    // Address wrap at 0xFFFFFF
    frame = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h02,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h14};
    w0 = wa.size(); d0 = done_cnt;
    send_frame(0, 1'b0);
    chk("w_nwrites", 32'(wa.size() - w0), 32'(2));
    chk_wr("w_w0", w0, 24'hFFFFFF, 24'h010203);
    chk_wr("w_w1", w0 + 1, 24'h000000, 24'h040506);
    chk("w_ndone", 32'(done_cnt - d0), 32'(1));

    // Stalled source with random gaps
    frame = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    w0 = wa.size(); d0 = done_cnt;
    send_frame(0, 1'b1);
    chk("s_nwrites", 32'(wa.size() - w0), 32'(2));
    chk_wr("s_w0", w0, 24'h000010, 24'h112233);
    chk_wr("s_w1", w0 + 1, 24'h000011, 24'h445566);
    chk("s_ndone", 32'(done_cnt - d0), 32'(1));
    chk("s_core_rel", 32'(core_rst), 32'(0));
    chk("s_err", 32'(err), 32'(0));

    // Async reset after the 7th byte
    w0 = wa.size();
    for (int i = 0; i < 7; i++) send(frame[i]);
    rst_n = 1'b0;
    #1;
    chk("m_ready", 32'(bus.ow_byte_ready), 32'(1));
    chk("m_we", 32'(bus.ow_mem_we), 32'(0));
    chk("m_addr", 32'(bus.ow_mem_addr), 32'(0));
    chk("m_wdata", 32'(bus.ow_mem_wdata), 32'(0));
    chk("m_core_rst", 32'(core_rst), 32'(1));
    chk("m_busy", 32'(busy), 32'(0));
    chk("m_done", 32'(done), 32'(0));
    chk("m_err", 32'(err), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("m_nwrites", 32'(wa.size() - w0), 32'(0));
    d0 = done_cnt;
    send_frame(0, 1'b0);
    chk("m_after_nwrites", 32'(wa.size() - w0), 32'(2));
    chk_wr("m_w0", w0, 24'h000010, 24'h112233);
    chk_wr("m_w1", w0 + 1, 24'h000011, 24'h445566);
    chk("m_after_ndone", 32'(done_cnt - d0), 32'(1));
    chk("m_after_core_rel", 32'(core_rst), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
